// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: program-load and run supervisor for the single-cycle core.
//
// Streams a program into instruction memory over a valid/ready interface.
// The core is held in reset while the program loads. The controller then
// releases the core and counts its cycles. A run ends on a fetched halt word
// or when the cycle budget runs out, and the result is reported in the flags.
//
// Ports:
//   clk, rst               rising-edge clock; synchronous active-low reset
//   start                  one-cycle pulse, begins a load from IDLE or DONE
//   load_valid/ready/data/last   program word stream
//   imem_we/addr/wdata     instruction-memory write port (1-cycle latency)
//   fetch_inst             word the core fetched this cycle
//   core_rst               active-high reset to the core
//   busy, done             LOAD/RUN and DONE status
//   halted, timeout        run-end cause
//   overflow               program exceeded DEPTH words
//   cycle_count            core cycles in the last or current run
//   words_loaded           words written in the last load
//   load_sig               (PROG_RUN_CTRL_SIGNATURE_EN only) rotate-xor
//                          signature of the loaded words
//
// Optional feature macro: PROG_RUN_CTRL_SIGNATURE_EN adds the load_sig output.
module prog_run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int MAX_CYCLES = 100,
  parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(32'h00000073)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] fetch_inst,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
`ifdef PROG_RUN_CTRL_SIGNATURE_EN
  ,
  output logic [DATA_W-1:0] load_sig
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  LAST_PTR   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  // S_ARM is the first RUN cycle: the final write is still in flight, so the
  // core stays in reset for one more cycle before its first fetch.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic              accept;
  logic              start_load;
  logic              at_end;
  logic              is_halt;
  logic              at_budget;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign accept     = load_valid && load_ready;
  assign start_load = start && (state == S_IDLE || state == S_DONE);
  assign at_end     = (words_loaded == LAST_PTR);
  assign is_halt    = (fetch_inst == HALT_INST);
  assign at_budget  = (cycle_count == LAST_CYCLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_LOAD;
      S_LOAD:         if (accept && (load_last || at_end)) state_n = S_ARM;
      S_ARM:          state_n = S_RUN;
      S_RUN:          if (is_halt || at_budget) state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == S_LOAD);
    core_rst   = (state != S_RUN);
    busy       = (state == S_LOAD) || (state == S_ARM) || (state == S_RUN);
    done       = (state == S_DONE);
  end

  // Stage p1: accepted beat registered onto the memory write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1  <= words_loaded[ADDR_W-1:0];
        wdata_p1 <= load_data;
      end
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;

  // words_loaded doubles as the write pointer; a full memory stops the load
  // before the pointer could wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      words_loaded <= '0;
      cycle_count  <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else if (start_load) begin
      words_loaded <= '0;
      cycle_count  <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (accept) begin
        words_loaded <= words_loaded + 1'b1;
        if (!load_last && at_end) overflow <= 1'b1;
      end
      if (state == S_RUN) begin
        cycle_count <= sat_inc(cycle_count);
        if (is_halt) begin
          halted <= 1'b1;
        end else if (at_budget) begin
          timeout <= 1'b1;
        end
      end
    end
  end

`ifdef PROG_RUN_CTRL_SIGNATURE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_sig <= '0;
    end else if (start_load) begin
      load_sig <= '0;
    end else if (accept) begin
      load_sig <= {load_sig[DATA_W-2:0], load_sig[DATA_W-1]} ^ load_data;
    end
  end
`endif

endmodule
